// File: rtl/matrix_link_if.sv
// Bundles the local TX request/status, the serial link wires in both directions and the
// received-edge outputs of matrix_link.
//   slave  : the matrix_link side (takes requests and link inputs, drives status and link outputs)
//   master : the user side (drives requests and link inputs, observes everything else)
interface matrix_link_if #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned LANES = 1
);
    // local transmit request
    logic             i_tx_start;
    logic [WIDTH-1:0] i_cells;
    logic             i_edge;
    // transmit status and outgoing link
    logic             o_tx_busy;
    logic             o_tx_done;
    logic             o_link_clk;
    logic             o_link_active;
    logic [LANES-1:0] o_link_data;
    // incoming link (asynchronous to clk)
    logic             i_link_clk;
    logic             i_link_active;
    logic [LANES-1:0] i_link_data;
    // received edge
    logic [WIDTH-1:0] o_cells;
    logic             o_edge;
    logic             o_rx_valid;
    logic             o_rx_err;
    logic             o_rx_busy;

    modport slave (
        input  i_tx_start, i_cells, i_edge,
        input  i_link_clk, i_link_active, i_link_data,
        output o_tx_busy, o_tx_done, o_link_clk, o_link_active, o_link_data,
        output o_cells, o_edge, o_rx_valid, o_rx_err, o_rx_busy
    );

    modport master (
        output i_tx_start, i_cells, i_edge,
        output i_link_clk, i_link_active, i_link_data,
        input  o_tx_busy, o_tx_done, o_link_clk, o_link_active, o_link_data,
        input  o_cells, o_edge, o_rx_valid, o_rx_err, o_rx_busy
    );
endinterface

// File: rtl/matrix_link.sv
// Full-duplex, multi-lane serial link that exchanges one matrix edge (WIDTH cells plus a
// corner bit) with a neighbouring chip. TX is link master: it snapshots the edge, generates
// the link clock and stripes N = WIDTH/LANES data beats, a corner beat and a parity beat
// over LANES wires. RX synchronises the neighbour's link, collects a frame and commits it
// atomically when parity matches, flagging parity errors and aborted frames.
// Ports:
//   clk     : system clock, all logic on posedge
//   reset_n : asynchronous active-low reset
//   bus     : matrix_link_if.slave -- TX request/status, link wires both ways, RX outputs
module matrix_link #(
    parameter int unsigned WIDTH       = 32,
    parameter int unsigned LANES       = 1,
    parameter int unsigned CLK_DIV     = 4,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic          clk,
    input  logic          reset_n,
    matrix_link_if.slave  bus
);

    localparam int unsigned N_BEATS = WIDTH / LANES;
    localparam int unsigned BEAT_W  = $clog2(N_BEATS + 3);
    localparam int unsigned IDX_W   = (N_BEATS > 1) ? $clog2(N_BEATS) : 1;
    localparam int unsigned DIV_W   = $clog2(CLK_DIV);
    localparam int unsigned SYNC_W  = LANES + 2;

    // beat indices: data beats 0..N-1, corner beat N, parity beat N+1, N+2 = frame complete
    localparam logic [BEAT_W-1:0] CORNER_B = BEAT_W'(N_BEATS);
    localparam logic [BEAT_W-1:0] PARITY_B = BEAT_W'(N_BEATS + 1);
    localparam logic [BEAT_W-1:0] END_B    = BEAT_W'(N_BEATS + 2);
    localparam logic [DIV_W-1:0]  DIV_LAST = DIV_W'(CLK_DIV - 1);

    // ------------------------------------------------------------------ TX
    typedef enum logic [1:0] {
        TX_IDLE = 2'd0,
        TX_LOW  = 2'd1,
        TX_HIGH = 2'd2,
        TX_TAIL = 2'd3
    } tx_state_t;

    tx_state_t                     tx_state,      tx_state_nxt;
    logic [DIV_W-1:0]              div_cnt,       div_cnt_nxt;
    logic [BEAT_W-1:0]             tx_beat,       tx_beat_nxt;
    logic [N_BEATS-1:0][LANES-1:0] tx_cells_q,    tx_cells_nxt;
    logic                          tx_edge_q,     tx_edge_nxt;
    logic                          link_clk_q,    link_clk_nxt;
    logic                          link_active_q, link_active_nxt;
    logic [LANES-1:0]              link_data_q,   link_data_nxt;
    logic                          tx_busy_q,     tx_busy_nxt;
    logic                          tx_done_q,     tx_done_nxt;

    logic [LANES-1:0]              tx_parity_c;
    logic [BEAT_W-1:0]             tx_beat_inc_c;
    logic [LANES-1:0]              tx_next_word_c;

    // per-lane parity over the snapshot's data beats and the corner beat
    always_comb begin
        tx_parity_c = '0;
        for (int k = 0; k < int'(N_BEATS); k++) begin
            tx_parity_c = tx_parity_c ^ tx_cells_q[k];
        end
        tx_parity_c[0] = tx_parity_c[0] ^ tx_edge_q;
    end

    // lane word of the beat following the current one
    always_comb begin
        tx_beat_inc_c = tx_beat + BEAT_W'(1);
        if (tx_beat_inc_c < CORNER_B) begin
            tx_next_word_c = tx_cells_q[IDX_W'(tx_beat_inc_c)];
        end else if (tx_beat_inc_c == CORNER_B) begin
            tx_next_word_c = LANES'(tx_edge_q);
        end else begin
            tx_next_word_c = tx_parity_c;
        end
    end

    // TX state and output registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tx_state      <= TX_IDLE;
            div_cnt       <= '0;
            tx_beat       <= '0;
            tx_cells_q    <= '0;
            tx_edge_q     <= 1'b0;
            link_clk_q    <= 1'b0;
            link_active_q <= 1'b0;
            link_data_q   <= '0;
            tx_busy_q     <= 1'b0;
            tx_done_q     <= 1'b0;
        end else begin
            tx_state      <= tx_state_nxt;
            div_cnt       <= div_cnt_nxt;
            tx_beat       <= tx_beat_nxt;
            tx_cells_q    <= tx_cells_nxt;
            tx_edge_q     <= tx_edge_nxt;
            link_clk_q    <= link_clk_nxt;
            link_active_q <= link_active_nxt;
            link_data_q   <= link_data_nxt;
            tx_busy_q     <= tx_busy_nxt;
            tx_done_q     <= tx_done_nxt;
        end
    end

    // TX next state / next outputs
    always_comb begin
        tx_state_nxt    = tx_state;
        div_cnt_nxt     = div_cnt;
        tx_beat_nxt     = tx_beat;
        tx_cells_nxt    = tx_cells_q;
        tx_edge_nxt     = tx_edge_q;
        link_clk_nxt    = link_clk_q;
        link_active_nxt = link_active_q;
        link_data_nxt   = link_data_q;
        tx_busy_nxt     = tx_busy_q;
        tx_done_nxt     = 1'b0;

        case (tx_state)
            TX_IDLE: begin
                // the done cycle is still treated as busy for new requests
                if (bus.i_tx_start && !tx_done_q) begin
                    tx_cells_nxt    = bus.i_cells;
                    tx_edge_nxt     = bus.i_edge;
                    div_cnt_nxt     = '0;
                    tx_beat_nxt     = '0;
                    link_clk_nxt    = 1'b0;
                    link_active_nxt = 1'b1;
                    link_data_nxt   = bus.i_cells[LANES-1:0];
                    tx_busy_nxt     = 1'b1;
                    tx_state_nxt    = TX_LOW;
                end
            end

            TX_LOW: begin
                if (div_cnt == DIV_LAST) begin
                    div_cnt_nxt  = '0;
                    link_clk_nxt = 1'b1;
                    tx_state_nxt = TX_HIGH;
                end else begin
                    div_cnt_nxt = div_cnt + DIV_W'(1);
                end
            end

            TX_HIGH: begin
                if (div_cnt == DIV_LAST) begin
                    div_cnt_nxt  = '0;
                    link_clk_nxt = 1'b0;
                    if (tx_beat == PARITY_B) begin
                        tx_state_nxt = TX_TAIL;
                    end else begin
                        // data only moves together with the falling link clock
                        tx_beat_nxt   = tx_beat_inc_c;
                        link_data_nxt = tx_next_word_c;
                        tx_state_nxt  = TX_LOW;
                    end
                end else begin
                    div_cnt_nxt = div_cnt + DIV_W'(1);
                end
            end

            TX_TAIL: begin
                if (div_cnt == DIV_LAST) begin
                    div_cnt_nxt     = '0;
                    tx_beat_nxt     = '0;
                    link_active_nxt = 1'b0;
                    link_data_nxt   = '0;
                    tx_busy_nxt     = 1'b0;
                    tx_done_nxt     = 1'b1;
                    tx_state_nxt    = TX_IDLE;
                end else begin
                    div_cnt_nxt = div_cnt + DIV_W'(1);
                end
            end

            default: begin
                tx_state_nxt = TX_IDLE;
            end
        endcase
    end

    assign bus.o_tx_busy     = tx_busy_q;
    assign bus.o_tx_done     = tx_done_q;
    assign bus.o_link_clk    = link_clk_q;
    assign bus.o_link_active = link_active_q;
    assign bus.o_link_data   = link_data_q;

    // ------------------------------------------------------------------ RX
    // one flop chain carries clk, active and all lanes so they stay aligned
    logic [SYNC_STAGES-1:0][SYNC_W-1:0] rx_sync_q;
    logic                               s_clk_c;
    logic                               s_active_c;
    logic [LANES-1:0]                   s_data_c;
    logic                               s_rise_c;

    logic                               rx_clk_prev;
    logic [BEAT_W-1:0]                  rx_cnt;
    logic [N_BEATS-1:0][LANES-1:0]      rx_shadow;
    logic                               rx_edge_shadow;
    logic [LANES-1:0]                   rx_par;
    logic [WIDTH-1:0]                   rx_cells_q;
    logic                               rx_edge_q;
    logic                               rx_valid_q;
    logic                               rx_err_q;
    logic                               rx_busy_q;

    // input synchroniser; index 0 is the newest stage
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rx_sync_q <= '0;
        end else begin
            rx_sync_q <= {rx_sync_q[SYNC_STAGES-2:0],
                          bus.i_link_clk, bus.i_link_active, bus.i_link_data};
        end
    end

    assign s_clk_c    = rx_sync_q[SYNC_STAGES-1][LANES+1];
    assign s_active_c = rx_sync_q[SYNC_STAGES-1][LANES];
    assign s_data_c   = rx_sync_q[SYNC_STAGES-1][LANES-1:0];
    assign s_rise_c   = s_clk_c && !rx_clk_prev;

    // frame collection, parity check and atomic commit
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rx_clk_prev    <= 1'b0;
            rx_cnt         <= '0;
            rx_shadow      <= '0;
            rx_edge_shadow <= 1'b0;
            rx_par         <= '0;
            rx_cells_q     <= '0;
            rx_edge_q      <= 1'b0;
            rx_valid_q     <= 1'b0;
            rx_err_q       <= 1'b0;
            rx_busy_q      <= 1'b0;
        end else begin
            rx_clk_prev <= s_clk_c;
            rx_valid_q  <= 1'b0;
            rx_err_q    <= 1'b0;
            if (!s_active_c) begin
                // a frame that ended before its parity beat is an abort
                if (rx_cnt != '0 && rx_cnt != END_B) begin
                    rx_err_q <= 1'b1;
                end
                rx_cnt    <= '0;
                rx_par    <= '0;
                rx_busy_q <= 1'b0;
            end else if (s_rise_c && rx_cnt != END_B) begin
                rx_cnt <= rx_cnt + BEAT_W'(1);
                if (rx_cnt < CORNER_B) begin
                    rx_shadow[IDX_W'(rx_cnt)] <= s_data_c;
                    rx_par                    <= rx_par ^ s_data_c;
                    rx_busy_q                 <= 1'b1;
                end else if (rx_cnt == CORNER_B) begin
                    rx_edge_shadow <= s_data_c[0];
                    rx_par         <= rx_par ^ s_data_c;
                    rx_busy_q      <= 1'b1;
                end else begin
                    // parity beat: later rising edges in this frame are ignored
                    rx_busy_q <= 1'b0;
                    if (rx_par == s_data_c) begin
                        rx_cells_q <= rx_shadow;
                        rx_edge_q  <= rx_edge_shadow;
                        rx_valid_q <= 1'b1;
                    end else begin
                        rx_err_q <= 1'b1;
                    end
                end
            end
        end
    end

    assign bus.o_cells    = rx_cells_q;
    assign bus.o_edge     = rx_edge_q;
    assign bus.o_rx_valid = rx_valid_q;
    assign bus.o_rx_err   = rx_err_q;
    assign bus.o_rx_busy  = rx_busy_q;

endmodule

// File: tb/tb_matrix_link.sv
// Self-checking bench for matrix_link: a 4-lane loopback instance with lane-flip and
// active-drop injection, plus three loopback instances sweeping LANES and CLK_DIV.
module tb_matrix_link;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------------------------------------------------------- main instance
    matrix_link_if #(.WIDTH(32), .LANES(4)) m_if ();
    matrix_link #(.WIDTH(32), .LANES(4), .CLK_DIV(2), .SYNC_STAGES(2)) u_main (
        .clk(clk), .reset_n(reset_n), .bus(m_if)
    );

    int   flip_beat = -1;
    int   kill_beat = -1;
    int   tx_beat_seen = 0;
    logic prev_lclk = 1'b0;
    logic kill_q = 1'b0;
    logic kill_c;
    logic [3:0] flip_c;
    logic [7:0] cap_q[$];

    assign kill_c = kill_q || (m_if.o_link_active && tx_beat_seen == kill_beat);
    assign flip_c = (m_if.o_link_active && tx_beat_seen == flip_beat) ? 4'b0100 : 4'b0000;
    assign m_if.i_link_clk    = m_if.o_link_clk;
    assign m_if.i_link_active = m_if.o_link_active && !kill_c;
    assign m_if.i_link_data   = m_if.o_link_data ^ flip_c;

    // ---------------------------------------------------------------- sweep instances
    logic        sw_start = 1'b0;
    logic [31:0] sw_cells = '0;
    logic        sw_edge  = 1'b0;
    int          sw_lanes[3] = '{1, 8, 8};
    int          sw_div[3]   = '{7, 2, 7};

    matrix_link_if #(.WIDTH(32), .LANES(1)) s0_if ();
    matrix_link_if #(.WIDTH(32), .LANES(8)) s1_if ();
    matrix_link_if #(.WIDTH(32), .LANES(8)) s2_if ();
    matrix_link #(.WIDTH(32), .LANES(1), .CLK_DIV(7), .SYNC_STAGES(2)) u_s0 (
        .clk(clk), .reset_n(reset_n), .bus(s0_if)
    );
    matrix_link #(.WIDTH(32), .LANES(8), .CLK_DIV(2), .SYNC_STAGES(3)) u_s1 (
        .clk(clk), .reset_n(reset_n), .bus(s1_if)
    );
    matrix_link #(.WIDTH(32), .LANES(8), .CLK_DIV(7), .SYNC_STAGES(2)) u_s2 (
        .clk(clk), .reset_n(reset_n), .bus(s2_if)
    );

    assign s0_if.i_tx_start = sw_start;  assign s0_if.i_cells = sw_cells;  assign s0_if.i_edge = sw_edge;
    assign s1_if.i_tx_start = sw_start;  assign s1_if.i_cells = sw_cells;  assign s1_if.i_edge = sw_edge;
    assign s2_if.i_tx_start = sw_start;  assign s2_if.i_cells = sw_cells;  assign s2_if.i_edge = sw_edge;
    assign s0_if.i_link_clk = s0_if.o_link_clk;  assign s0_if.i_link_active = s0_if.o_link_active;
    assign s1_if.i_link_clk = s1_if.o_link_clk;  assign s1_if.i_link_active = s1_if.o_link_active;
    assign s2_if.i_link_clk = s2_if.o_link_clk;  assign s2_if.i_link_active = s2_if.o_link_active;
    assign s0_if.i_link_data = s0_if.o_link_data;
    assign s1_if.i_link_data = s1_if.o_link_data;
    assign s2_if.i_link_data = s2_if.o_link_data;

    logic [31:0] sw_rx_cells[3];
    logic        sw_rx_edge[3];
    assign sw_rx_cells[0] = s0_if.o_cells;  assign sw_rx_edge[0] = s0_if.o_edge;
    assign sw_rx_cells[1] = s1_if.o_cells;  assign sw_rx_edge[1] = s1_if.o_edge;
    assign sw_rx_cells[2] = s2_if.o_cells;  assign sw_rx_edge[2] = s2_if.o_edge;

    // ---------------------------------------------------------------- monitors
    logic [3:0] mon_valid, mon_err, mon_done;
    assign mon_valid = {s2_if.o_rx_valid, s1_if.o_rx_valid, s0_if.o_rx_valid, m_if.o_rx_valid};
    assign mon_err   = {s2_if.o_rx_err,   s1_if.o_rx_err,   s0_if.o_rx_err,   m_if.o_rx_err};
    assign mon_done  = {s2_if.o_tx_done,  s1_if.o_tx_done,  s0_if.o_tx_done,  m_if.o_tx_done};

    int vcnt[4]     = '{0, 0, 0, 0};
    int ecnt[4]     = '{0, 0, 0, 0};
    int done_cyc[4] = '{-1, -1, -1, -1};
    int both_hi     = 0;

    always @(negedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (mon_valid[i]) vcnt[i] <= vcnt[i] + 1;
            if (mon_err[i])   ecnt[i] <= ecnt[i] + 1;
            if (mon_done[i])  done_cyc[i] <= cyc;
            if (mon_valid[i] && mon_err[i]) both_hi <= both_hi + 1;
        end
        // beat tracking and capture of the main transmitter
        if (!m_if.o_link_active) begin
            tx_beat_seen <= 0;
            kill_q       <= 1'b0;
        end else begin
            if (prev_lclk && !m_if.o_link_clk) tx_beat_seen <= tx_beat_seen + 1;
            if (kill_c) kill_q <= 1'b1;
            if (!prev_lclk && m_if.o_link_clk) cap_q.push_back(8'(m_if.o_link_data));
        end
        prev_lclk <= m_if.o_link_clk;
    end

    // ---------------------------------------------------------------- reference model
    // lane word of beat k for an edge striped over 'lanes' wires
    function automatic logic [7:0] model_beat(input logic [31:0] cells, input logic edge_b,
                                              input int lanes, input int k);
        int n = 32 / lanes;
        logic [7:0] b = '0;
        for (int l = 0; l < lanes; l++) begin
            if (k < n) begin
                b[l] = cells[k * lanes + l];
            end else begin
                b[l] = (l == 0) ? edge_b : 1'b0;
                if (k == n + 1) begin
                    for (int j = l; j < 32; j += lanes) b[l] = b[l] ^ cells[j];
                end
            end
        end
        return b;
    endfunction

    function automatic int model_done_delay(input int lanes, input int div);
        return 1 + (32 / lanes + 2) * 2 * div + div;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // one main-instance frame; i_cells/i_edge are scrambled 5 cycles in, extra_at pulses a
    // second start that many cycles after the first
    task automatic main_frame(input logic [31:0] cells, input logic edge_b, input int extra_at,
                              output int tdelay, output logic busy_mid);
        int t0;
        cap_q.delete();
        @(negedge clk);
        m_if.i_cells = cells;  m_if.i_edge = edge_b;  m_if.i_tx_start = 1'b1;
        t0 = cyc;
        tdelay = -1;
        busy_mid = 1'b0;
        for (int i = 1; i < 400 && tdelay < 0; i++) begin
            @(negedge clk);
            m_if.i_tx_start = 1'b0;
            if (i == 5) begin m_if.i_cells = ~cells; m_if.i_edge = ~edge_b; end
            if (i == extra_at) m_if.i_tx_start = 1'b1;
            if (i == 20) busy_mid = m_if.o_rx_busy;
            if (m_if.o_tx_done) tdelay = cyc - t0;
        end
        m_if.i_tx_start = 1'b0;
        repeat (12) @(negedge clk);
    endtask

    // ---------------------------------------------------------------- stimulus
    initial begin
        int          td;
        int          v0, e0, t0;
        int          sv[3], se[3];
        logic        bm;
        logic [31:0] c;
        logic        eb;
        int          exp_td;

        m_if.i_tx_start = 1'b0;
        m_if.i_cells    = '0;
        m_if.i_edge     = 1'b0;
        exp_td = model_done_delay(4, 2);

        // reset state
        repeat (3) @(negedge clk);
        check("rst_link_active", 64'(m_if.o_link_active), 64'd0);
        check("rst_link_clk",    64'(m_if.o_link_clk),    64'd0);
        check("rst_link_data",   64'(m_if.o_link_data),   64'd0);
        check("rst_tx_busy",     64'(m_if.o_tx_busy),     64'd0);
        check("rst_cells",       64'(m_if.o_cells),       64'd0);
        check("rst_rx_flags",    64'({m_if.o_rx_valid, m_if.o_rx_err, m_if.o_rx_busy, m_if.o_tx_done}), 64'd0);
        reset_n = 1'b1;
        repeat (4) @(negedge clk);

        // loopback with snapshot: edge data scrambled mid-transfer must not leak into the frame
        v0 = vcnt[0];  e0 = ecnt[0];
        main_frame(32'hDEADBEEF, 1'b1, 0, td, bm);
        check("t1_done_cycle", 64'(td), 64'(exp_td));
        check("t1_rx_busy_mid", 64'(bm), 64'd1);
        check("t1_valid_cnt", 64'(vcnt[0] - v0), 64'd1);
        check("t1_err_cnt",   64'(ecnt[0] - e0), 64'd0);
        check("t1_cells",     64'(m_if.o_cells), 64'hDEADBEEF);
        check("t1_edge",      64'(m_if.o_edge),  64'd1);
        check("t1_beat_count", 64'(cap_q.size()), 64'd10);
        for (int k = 0; k < 10; k++) begin
            check($sformatf("t1_beat%0d", k), 64'((k < cap_q.size()) ? cap_q[k] : 8'hFF),
                  64'(model_beat(32'hDEADBEEF, 1'b1, 4, k)));
        end

        // lane 2 corrupted during beat 3: parity error, previous edge kept
        flip_beat = 3;
        v0 = vcnt[0];  e0 = ecnt[0];
        main_frame($urandom, 1'($urandom), 0, td, bm);
        flip_beat = -1;
        check("t3_err_cnt",   64'(ecnt[0] - e0), 64'd1);
        check("t3_valid_cnt", 64'(vcnt[0] - v0), 64'd0);
        check("t3_cells_kept", 64'(m_if.o_cells), 64'hDEADBEEF);
        check("t3_edge_kept",  64'(m_if.o_edge),  64'd1);

        // active dropped after 4 beats: abort, then a clean frame recovers
        kill_beat = 4;
        v0 = vcnt[0];  e0 = ecnt[0];
        main_frame($urandom, 1'b0, 0, td, bm);
        kill_beat = -1;
        check("t4_err_cnt",   64'(ecnt[0] - e0), 64'd1);
        check("t4_valid_cnt", 64'(vcnt[0] - v0), 64'd0);
        check("t4_rx_busy",   64'(m_if.o_rx_busy), 64'd0);
        check("t4_cells_kept", 64'(m_if.o_cells), 64'hDEADBEEF);
        v0 = vcnt[0];  e0 = ecnt[0];
        main_frame(32'h00000001, 1'b0, 0, td, bm);
        check("t4b_valid_cnt", 64'(vcnt[0] - v0), 64'd1);
        check("t4b_err_cnt",   64'(ecnt[0] - e0), 64'd0);
        check("t4b_cells",     64'(m_if.o_cells), 64'h00000001);
        check("t4b_edge",      64'(m_if.o_edge),  64'd0);

        // random frames on the lane / divider sweep
        for (int r = 0; r < 5; r++) begin
            c  = $urandom;
            eb = 1'($urandom);
            for (int i = 0; i < 3; i++) begin sv[i] = vcnt[i + 1]; se[i] = ecnt[i + 1]; end
            @(negedge clk);
            sw_cells = c;  sw_edge = eb;  sw_start = 1'b1;
            t0 = cyc;
            @(negedge clk);
            sw_start = 1'b0;
            repeat (4) @(negedge clk);
            sw_cells = $urandom;  sw_edge = ~eb;
            for (int i = 0; i < 1500; i++) begin
                @(negedge clk);
                if (done_cyc[1] > t0 && done_cyc[2] > t0 && done_cyc[3] > t0) break;
            end
            repeat (16) @(negedge clk);
            for (int i = 0; i < 3; i++) begin
                check($sformatf("sw%0d_r%0d_done", i, r), 64'(done_cyc[i + 1] - t0),
                      64'(model_done_delay(sw_lanes[i], sw_div[i])));
                check($sformatf("sw%0d_r%0d_cells", i, r), 64'(sw_rx_cells[i]), 64'(c));
                check($sformatf("sw%0d_r%0d_edge", i, r), 64'(sw_rx_edge[i]), 64'(eb));
                check($sformatf("sw%0d_r%0d_valid", i, r), 64'(vcnt[i + 1] - sv[i]), 64'd1);
                check($sformatf("sw%0d_r%0d_err", i, r), 64'(ecnt[i + 1] - se[i]), 64'd0);
            end
        end

        // start while busy is ignored
        v0 = vcnt[0];
        c = $urandom;
        main_frame(c, 1'b1, 10, td, bm);
        check("t5_done_cycle", 64'(td), 64'(exp_td));
        check("t5_valid_cnt",  64'(vcnt[0] - v0), 64'd1);
        check("t5_cells",      64'(m_if.o_cells), 64'(c));
        check("t5_idle_after", 64'(m_if.o_tx_busy), 64'd0);

        // start in the same cycle as done is ignored
        @(negedge clk);
        m_if.i_cells = $urandom;  m_if.i_tx_start = 1'b1;
        td = -1;
        for (int i = 1; i < 400 && td < 0; i++) begin
            @(negedge clk);
            m_if.i_tx_start = 1'b0;
            if (m_if.o_tx_done) begin
                td = i;
                m_if.i_tx_start = 1'b1;
            end
        end
        check("t5_done_seen", 64'(td), 64'(exp_td));
        @(negedge clk);
        m_if.i_tx_start = 1'b0;
        check("t5_start_on_done_busy",   64'(m_if.o_tx_busy),     64'd0);
        check("t5_start_on_done_active", 64'(m_if.o_link_active), 64'd0);

        // asynchronous reset in the middle of a frame
        @(negedge clk);
        m_if.i_cells = $urandom;  m_if.i_tx_start = 1'b1;
        @(negedge clk);
        m_if.i_tx_start = 1'b0;
        repeat (6) @(negedge clk);
        for (int i = 0; i < 20 && !m_if.o_link_clk; i++) @(negedge clk);
        check("t5_mid_clk_high", 64'(m_if.o_link_clk & m_if.o_tx_busy), 64'd1);
        #1 reset_n = 1'b0;
        #1;
        check("t5_rst_active", 64'(m_if.o_link_active), 64'd0);
        check("t5_rst_clk",    64'(m_if.o_link_clk),    64'd0);
        check("t5_rst_busy",   64'(m_if.o_tx_busy),     64'd0);
        check("t5_rst_cells",  64'(m_if.o_cells),       64'd0);

        check("valid_err_overlap", 64'(both_hi), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
